// File: rtl/control_unit_mc_if.sv
// Bundle of the instruction-register, data-memory handshake and datapath
// control signals that connect to control_unit_mc.
//
// Handshake: OPCODE is taken on a rising edge where INSTR_VALID=1 and the
// unit can accept. It can accept when it is idle, or when the registered
// STALL is 0 in an EXEC cycle, a final MUL cycle or a memory completion
// cycle. It does not accept in the cycle where ILLEGAL=1. While STALL=1,
// OPCODE and INSTR_VALID are ignored. MEM_BUSYWAIT=1 holds a memory access
// and is sampled on every rising edge from the decode edge onward.
interface control_unit_mc_if #(
    parameter int OPC_W   = 8,
    parameter int ALUOP_W = 3
);
    logic [OPC_W-1:0]   OPCODE;
    logic               INSTR_VALID;
    logic               MEM_BUSYWAIT;
    logic               IMM;
    logic               SIGN;
    logic [ALUOP_W-1:0] ALUOP;
    logic               WRITEENABLE;
    logic               J;
    logic               BEQ;
    logic               BNE;
    logic               MEM_READ;
    logic               MEM_WRITE;
    logic               WB_SEL;
    logic               STALL;
    logic               ILLEGAL;

    // Instruction register / data memory side
    modport master (
        output OPCODE, INSTR_VALID, MEM_BUSYWAIT,
        input  IMM, SIGN, ALUOP, WRITEENABLE, J, BEQ, BNE,
               MEM_READ, MEM_WRITE, WB_SEL, STALL, ILLEGAL
    );

    // Control unit side
    modport slave (
        input  OPCODE, INSTR_VALID, MEM_BUSYWAIT,
        output IMM, SIGN, ALUOP, WRITEENABLE, J, BEQ, BNE,
               MEM_READ, MEM_WRITE, WB_SEL, STALL, ILLEGAL
    );
endinterface

// File: rtl/control_unit_mc.sv
// Multi-cycle control unit. It decodes the opcode into registered datapath
// controls, sequences MUL over MUL_LAT cycles and sequences data-memory
// accesses against MEM_BUSYWAIT. STALL holds the PC and IR until the
// instruction retires. o_dbg_state exposes the FSM state:
// 0 IDLE, 1 EXEC, 2 MUL, 3 MEM, 4 ERR.
module control_unit_mc #(
    parameter int OPC_W   = 8,
    parameter int ALUOP_W = 3,
    parameter int MUL_LAT = 3
) (
    input  logic              CLK,
    input  logic              RESET,
    control_unit_mc_if.slave  bus,
    output logic [2:0]        o_dbg_state
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    localparam logic [OPC_W-1:0] OP_LOADI = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_MOV   = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_ADD   = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_SUB   = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_AND   = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_OR    = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_J     = OPC_W'(8'h06);
    localparam logic [OPC_W-1:0] OP_BEQ   = OPC_W'(8'h07);
    localparam logic [OPC_W-1:0] OP_BNE   = OPC_W'(8'h08);
    localparam logic [OPC_W-1:0] OP_MUL   = OPC_W'(8'h09);
    localparam logic [OPC_W-1:0] OP_LWD   = OPC_W'(8'h0A);
    localparam logic [OPC_W-1:0] OP_LWI   = OPC_W'(8'h0B);
    localparam logic [OPC_W-1:0] OP_SWD   = OPC_W'(8'h0C);
    localparam logic [OPC_W-1:0] OP_SWI   = OPC_W'(8'h0D);

    localparam logic [ALUOP_W-1:0] ALU_FWD = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_ADD = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_AND = ALUOP_W'(3'b010);
    localparam logic [ALUOP_W-1:0] ALU_OR  = ALUOP_W'(3'b011);
    localparam logic [ALUOP_W-1:0] ALU_MUL = ALUOP_W'(3'b100);

    // The remaining-cycle counter only needs to hold MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

    typedef struct packed {
        logic               imm;
        logic               sign;
        logic [ALUOP_W-1:0] aluop;
        logic               we;
        logic               j;
        logic               beq;
        logic               bne;
        logic               mem_read;
        logic               mem_write;
        logic               wb_sel;
        logic               stall;
        logic               illegal;
    } ctl_t;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [OPC_W-1:0] r_opcode;
    ctl_t             r_ctl;

    logic [2:0]       w_dec_state;
    ctl_t             w_dec;
    logic [2:0]       w_nx_state;
    logic [CNT_W-1:0] w_nx_cnt;
    logic [OPC_W-1:0] w_nx_opcode;
    ctl_t             w_nx;
    logic             w_accept;
    logic             w_is_load;

    assign w_is_load = (r_opcode == OP_LWD) || (r_opcode == OP_LWI);

    // Static decode of the incoming opcode: field values and target state
    always_comb begin
        w_dec_state = S_EXEC;
        w_dec       = '0;
        case (bus.OPCODE)
            OP_LOADI: begin w_dec.imm = 1'b1; w_dec.we = 1'b1; end
            OP_MOV:   begin w_dec.we = 1'b1; end
            OP_ADD:   begin w_dec.aluop = ALU_ADD; w_dec.we = 1'b1; end
            OP_SUB:   begin w_dec.sign = 1'b1; w_dec.aluop = ALU_ADD; w_dec.we = 1'b1; end
            OP_AND:   begin w_dec.aluop = ALU_AND; w_dec.we = 1'b1; end
            OP_OR:    begin w_dec.aluop = ALU_OR;  w_dec.we = 1'b1; end
            OP_J:     begin w_dec.aluop = ALU_FWD; w_dec.j = 1'b1; end
            OP_BEQ:   begin w_dec.sign = 1'b1; w_dec.aluop = ALU_ADD; w_dec.beq = 1'b1; end
            OP_BNE:   begin w_dec.sign = 1'b1; w_dec.aluop = ALU_ADD; w_dec.bne = 1'b1; end
            OP_MUL:   begin w_dec_state = S_MUL; w_dec.aluop = ALU_MUL; end
            OP_LWD:   begin w_dec_state = S_MEM; w_dec.mem_read = 1'b1; end
            OP_LWI:   begin w_dec_state = S_MEM; w_dec.mem_read = 1'b1; w_dec.imm = 1'b1; end
            OP_SWD:   begin w_dec_state = S_MEM; w_dec.mem_write = 1'b1; end
            OP_SWI:   begin w_dec_state = S_MEM; w_dec.mem_write = 1'b1; w_dec.imm = 1'b1; end
            default:  begin w_dec_state = S_ERR; w_dec.illegal = 1'b1; end
        endcase
    end

    // Next state and next registered controls for the current FSM state
    always_comb begin
        w_nx_state  = S_IDLE;
        w_nx_cnt    = '0;
        w_nx_opcode = r_opcode;
        w_nx        = '0;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_EXEC: w_accept = bus.INSTR_VALID;
            S_MUL: begin
                if (r_cnt != '0) begin
                    // Still multiplying: hold the latched controls.
                    w_nx_state = S_MUL;
                    w_nx_cnt   = r_cnt - 1'b1;
                    w_nx.aluop = r_ctl.aluop;
                    w_nx.stall = (r_cnt != CNT_W'(1));
                    w_nx.we    = (r_cnt == CNT_W'(1));
                end else begin
                    w_accept = bus.INSTR_VALID;
                end
            end
            S_MEM: begin
                if (r_ctl.stall) begin
                    // Waiting on memory: keep the request and operand selects up.
                    w_nx_state     = S_MEM;
                    w_nx.imm       = r_ctl.imm;
                    w_nx.aluop     = r_ctl.aluop;
                    w_nx.mem_read  = r_ctl.mem_read;
                    w_nx.mem_write = r_ctl.mem_write;
                    if (bus.MEM_BUSYWAIT) begin
                        w_nx.stall = 1'b1;
                    end else begin
                        w_nx.we     = w_is_load;
                        w_nx.wb_sel = w_is_load;
                    end
                end else begin
                    w_accept = bus.INSTR_VALID;
                end
            end
            default: ;  // ERR, or an unused encoding, returns to IDLE with all strobes low
        endcase

        if (w_accept) begin
            w_nx_opcode = bus.OPCODE;
            w_nx_state  = w_dec_state;
            w_nx        = w_dec;
            if (w_dec_state == S_MUL) begin
                w_nx_cnt   = CNT_W'(MUL_LAT - 1);
                w_nx.stall = (MUL_LAT > 1);
                w_nx.we    = (MUL_LAT == 1);
            end else if (w_dec_state == S_MEM) begin
                // An access that is not busy at decode completes in its first cycle.
                w_nx.stall  = bus.MEM_BUSYWAIT;
                w_nx.we     = w_dec.mem_read & ~bus.MEM_BUSYWAIT;
                w_nx.wb_sel = w_dec.mem_read & ~bus.MEM_BUSYWAIT;
            end
        end
    end

    // State, counter, latched opcode and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_opcode <= '0;
            r_ctl    <= '0;
        end else begin
            r_state  <= w_nx_state;
            r_cnt    <= w_nx_cnt;
            r_opcode <= w_nx_opcode;
            r_ctl    <= w_nx;
        end
    end

    assign bus.IMM         = r_ctl.imm;
    assign bus.SIGN        = r_ctl.sign;
    assign bus.ALUOP       = r_ctl.aluop;
    assign bus.WRITEENABLE = r_ctl.we;
    assign bus.J           = r_ctl.j;
    assign bus.BEQ         = r_ctl.beq;
    assign bus.BNE         = r_ctl.bne;
    assign bus.MEM_READ    = r_ctl.mem_read;
    assign bus.MEM_WRITE   = r_ctl.mem_write;
    assign bus.WB_SEL      = r_ctl.wb_sel;
    assign bus.STALL       = r_ctl.stall;
    assign bus.ILLEGAL     = r_ctl.illegal;
    assign o_dbg_state     = r_state;
endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc (MUL_LAT=3). Inputs are driven 1 ns
// after a rising edge and outputs are sampled 1 ns after the next edge.
module tb_control_unit_mc;
    localparam int OPC_W   = 8;
    localparam int ALUOP_W = 3;
    localparam int MUL_LAT = 3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_EXEC = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_MEM  = 3'd3;
    localparam logic [2:0] S_ERR  = 3'd4;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [2:0]  dbg_state;
    logic [13:0] outs;
    int          checks = 0;
    int          errors = 0;

    control_unit_mc_if #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W)) bus ();

    control_unit_mc #(.OPC_W(OPC_W), .ALUOP_W(ALUOP_W), .MUL_LAT(MUL_LAT)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .bus         (bus.slave),
        .o_dbg_state (dbg_state)
    );

    always #5 CLK = ~CLK;

    // {IMM,SIGN,ALUOP[2:0],WE,J,BEQ,BNE,MEM_READ,MEM_WRITE,WB_SEL,STALL,ILLEGAL}
    assign outs = {bus.IMM, bus.SIGN, bus.ALUOP, bus.WRITEENABLE, bus.J, bus.BEQ,
                   bus.BNE, bus.MEM_READ, bus.MEM_WRITE, bus.WB_SEL, bus.STALL, bus.ILLEGAL};

    function automatic logic [13:0] ctl(input logic imm, input logic sign, input logic [2:0] aluop,
                                        input logic we, input logic j, input logic beq, input logic bne,
                                        input logic mr, input logic mw, input logic wb,
                                        input logic st, input logic il);
        return {imm, sign, aluop, we, j, beq, bne, mr, mw, wb, st, il};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [7:0] opc, input logic valid, input logic busy);
        bus.OPCODE       = opc;
        bus.INSTR_VALID  = valid;
        bus.MEM_BUSYWAIT = busy;
    endtask

    task automatic test_reset();
        logic [13:0] exp_v;
        RESET = 1'b1;
        drive(8'h02, 1'b1, 1'b0);
        tick();
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL reset_outs got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d exp %0d", dbg_state, S_IDLE); end
        drive(8'h00, 1'b0, 1'b0);
        RESET = 1'b0;
        tick();
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL idle_outs got %b exp %b", outs, exp_v); end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp_v;
        drive(8'h02, 1'b1, 1'b0);  // ADD
        tick();
        exp_v = ctl(0, 0, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL b2b_add got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_EXEC) begin errors++; $display("FAIL b2b_add_state got %0d exp %0d", dbg_state, S_EXEC); end
        drive(8'h03, 1'b1, 1'b0);  // SUB
        tick();
        exp_v = ctl(0, 1, 3'b001, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL b2b_sub got %b exp %b", outs, exp_v); end
        drive(8'h00, 1'b0, 1'b0);
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL b2b_idle got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL b2b_idle_state got %0d exp %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_alu_ops();
        logic [7:0]  opc_tab [7];
        logic [13:0] exp_tab [7];
        logic [13:0] exp_v;
        opc_tab[0] = 8'h00; exp_tab[0] = ctl(1, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // LOADI
        opc_tab[1] = 8'h01; exp_tab[1] = ctl(0, 0, 3'b000, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // MOV
        opc_tab[2] = 8'h04; exp_tab[2] = ctl(0, 0, 3'b010, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // AND
        opc_tab[3] = 8'h05; exp_tab[3] = ctl(0, 0, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // OR
        opc_tab[4] = 8'h06; exp_tab[4] = ctl(0, 0, 3'b000, 0, 1, 0, 0, 0, 0, 0, 0, 0);  // J
        opc_tab[5] = 8'h07; exp_tab[5] = ctl(0, 1, 3'b001, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // BEQ
        opc_tab[6] = 8'h08; exp_tab[6] = ctl(0, 1, 3'b001, 0, 0, 0, 1, 0, 0, 0, 0, 0);  // BNE
        for (int i = 0; i < 7; i++) begin
            drive(opc_tab[i], 1'b1, 1'b0);
            tick();
            checks++; if (outs !== exp_tab[i]) begin errors++; $display("FAIL op_%02h got %b exp %b", opc_tab[i], outs, exp_tab[i]); end
            drive(8'h00, 1'b0, 1'b0);
            tick();
            exp_v = '0;
            checks++; if (outs !== exp_v) begin errors++; $display("FAIL op_%02h_idle got %b exp %b", opc_tab[i], outs, exp_v); end
        end
    endtask

    task automatic test_mul();
        logic [13:0] exp_v;
        drive(8'h09, 1'b1, 1'b0);
        tick();
        exp_v = ctl(0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL mul_c1 got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_MUL) begin errors++; $display("FAIL mul_state got %0d exp %0d", dbg_state, S_MUL); end
        drive(8'h02, 1'b1, 1'b0);  // must be ignored while stalled
        tick();
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL mul_c2 got %b exp %b", outs, exp_v); end
        tick();
        exp_v = ctl(0, 0, 3'b100, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL mul_c3 got %b exp %b", outs, exp_v); end
        drive(8'h00, 1'b0, 1'b0);
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL mul_done got %b exp %b", outs, exp_v); end
    endtask

    task automatic test_lwd_busy();
        logic [13:0] exp_v;
        drive(8'h0A, 1'b1, 1'b1);
        tick();
        exp_v = ctl(0, 0, 3'b000, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL lwd_c1 got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_MEM) begin errors++; $display("FAIL lwd_state got %0d exp %0d", dbg_state, S_MEM); end
        drive(8'h02, 1'b0, 1'b1);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checks++; if (outs !== exp_v) begin errors++; $display("FAIL lwd_c%0d got %b exp %b", i, outs, exp_v); end
        end
        drive(8'h02, 1'b0, 1'b0);
        tick();
        exp_v = ctl(0, 0, 3'b000, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL lwd_c5 got %b exp %b", outs, exp_v); end
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL lwd_done got %b exp %b", outs, exp_v); end
    endtask

    task automatic test_mem_nowait();
        logic [13:0] exp_v;
        drive(8'h0D, 1'b1, 1'b0);  // SWI
        tick();
        exp_v = ctl(1, 0, 3'b000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL swi_c1 got %b exp %b", outs, exp_v); end
        drive(8'h0B, 1'b1, 1'b0);  // LWI issued right after the store completes
        tick();
        exp_v = ctl(1, 0, 3'b000, 1, 0, 0, 0, 1, 0, 1, 0, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL lwi_c1 got %b exp %b", outs, exp_v); end
        drive(8'h00, 1'b0, 1'b0);
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL mem_done got %b exp %b", outs, exp_v); end
    endtask

    task automatic test_illegal();
        logic [13:0] exp_v;
        drive(8'hFF, 1'b1, 1'b0);
        tick();
        exp_v = ctl(0, 0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL ill_c1 got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_ERR) begin errors++; $display("FAIL ill_state got %0d exp %0d", dbg_state, S_ERR); end
        drive(8'h00, 1'b0, 1'b0);
        tick();
        exp_v = '0;
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL ill_c2 got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL ill_idle got %0d exp %0d", dbg_state, S_IDLE); end
    endtask

    task automatic test_reset_mid_mul();
        logic [13:0] exp_v;
        drive(8'h09, 1'b1, 1'b0);
        tick();
        drive(8'h00, 1'b0, 1'b0);
        tick();
        exp_v = ctl(0, 0, 3'b100, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL rmul_stall got %b exp %b", outs, exp_v); end
        RESET = 1'b1;
        exp_v = '0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (outs !== exp_v) begin errors++; $display("FAIL rmul_rst%0d got %b exp %b", i, outs, exp_v); end
        end
        RESET = 1'b0;
        tick();
        checks++; if (outs !== exp_v) begin errors++; $display("FAIL rmul_after got %b exp %b", outs, exp_v); end
        checks++; if (dbg_state !== S_IDLE) begin errors++; $display("FAIL rmul_state got %0d exp %0d", dbg_state, S_IDLE); end
    endtask

    initial begin
        RESET = 1'b1;
        drive(8'h00, 1'b0, 1'b0);
        test_reset();
        test_back_to_back();
        test_alu_ops();
        test_mul();
        test_lwd_busy();
        test_mem_nowait();
        test_illegal();
        test_reset_mid_mul();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
